instruction_fetch: RTL

//  Upstream stage of instruction_decoder. Owns the program counter, reads 8-bit

---
 rtl/instruction_fetch.sv | 126 ++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the PC, prefetches from a 1-cycle sync memory
// into a small buffer, and supports jump redirect with flush.
module instruction_fetch #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] CAP = (CNT_W+1)'(DEPTH);

  typedef enum logic {
    RUN,
    REDIRECT
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tag_q;
  logic              inflight_q;
  entry_t            fifo_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W:0]    credit;
  logic              pop;
  logic              push;
  logic              issue;

  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid & instr_ready;
  // A read landing in a jump cycle belongs to the old stream.
  assign push        = inflight_q & ~jump_valid;

  assign credit = {1'b0, count_q}
                + {{CNT_W{1'b0}}, inflight_q}
                - {{CNT_W{1'b0}}, pop};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    issue   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (jump_valid) begin
          state_d = REDIRECT;
          pc_d    = jump_target;
        end else begin
          issue = rst_n & ~halt & (credit < CAP);
          if (issue) pc_d = pc_q + ADDR_W'(1);
        end
      end
      REDIRECT: begin
        state_d = RUN;
        if (jump_valid) begin
          state_d = REDIRECT;
          pc_d    = jump_target;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (jump_valid) count_d = '0;
    else count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  assign mem_rd_en = issue;
  assign mem_addr  = pc_q;
  assign instr     = fifo_q[rd_ptr_q].data;
  assign instr_pc  = fifo_q[rd_ptr_q].pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= '0;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= issue;
      count_q    <= count_d;
      if (issue) tag_q <= pc_q;
      if (jump_valid) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else if (push) begin
      fifo_q[wr_ptr_q] <= '{data: mem_rdata, pc: tag_q};
    end
  end

endmodule
